// File: rtl/sync_fifo_flags_pkg.sv
// Shared types and defaults for the single-clock FIFO with occupancy flags.
package fifo_pkg;

   localparam int DSIZE_DEF = 8;
   localparam int ASIZE_DEF = 4;

   typedef logic [ASIZE_DEF:0] count_t;

   typedef enum logic {
      RD_REG  = 1'b0,
      RD_FWFT = 1'b1
   } rd_mode_t;

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Write/read handshake, data and status bundle of sync_fifo_flags.
interface sync_fifo_flags_if #(
   parameter int DSIZE = fifo_pkg::DSIZE_DEF,
   parameter int ASIZE = fifo_pkg::ASIZE_DEF
);

   logic             winc;
   logic [DSIZE-1:0] wdata;
   logic             rinc;
   logic [DSIZE-1:0] rdata;
   logic             wfull;
   logic             rempty;
   logic             almost_full;
   logic             almost_empty;
   logic [ASIZE:0]   count;
   logic             overflow;
   logic             underflow;
   logic             clr_err;

   modport master (
      output winc, wdata, rinc, clr_err,
      input  rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  winc, wdata, rinc, clr_err,
      output rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
   );

endinterface

// File: rtl/sync_fifo_flags_mem.sv
// DEPTH x DSIZE storage: synchronous write, asynchronous read, no reset.
module fifo_mem #(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ASIZE-1:0] waddr,
   input  logic [DSIZE-1:0] wdata,
   input  logic [ASIZE-1:0] raddr,
   output logic [DSIZE-1:0] rdata
);

   logic [DSIZE-1:0] mem [2**ASIZE];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost flags, sticky error flags and
// selectable registered / first-word-fall-through read.
module sync_fifo_flags
   import fifo_pkg::*;
#(
   parameter int DSIZE     = DSIZE_DEF,
   parameter int ASIZE     = ASIZE_DEF,
   parameter int AFULL_TH  = 14,
   parameter int AEMPTY_TH = 2,
   parameter int FWFT      = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   sync_fifo_flags_if.slave  bus
);

   localparam int       DEPTH   = 2**ASIZE;
   localparam rd_mode_t RD_MODE = (FWFT != 0) ? RD_FWFT : RD_REG;

   typedef logic [ASIZE:0]   cnt_t;
   typedef logic [ASIZE-1:0] ptr_t;

   if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull_th
      $error("sync_fifo_flags: AFULL_TH=%0d outside 1..%0d", AFULL_TH, DEPTH);
   end
   if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty_th
      $error("sync_fifo_flags: AEMPTY_TH=%0d outside 0..%0d", AEMPTY_TH, DEPTH - 1);
   end

   ptr_t             wptr;
   ptr_t             rptr;
   cnt_t             count_q;
   cnt_t             count_next;
   logic             wfull_q;
   logic             rempty_q;
   logic             afull_q;
   logic             aempty_q;
   logic             overflow_q;
   logic             underflow_q;
   logic             wr_acc;
   logic             rd_acc;
   logic [DSIZE-1:0] mem_rdata;

   // Accepts look only at registered flags, so no input reaches a flag combinationally.
   always_comb begin
      wr_acc     = bus.winc && !wfull_q;
      rd_acc     = bus.rinc && !rempty_q;
      count_next = count_q + cnt_t'(wr_acc) - cnt_t'(rd_acc);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr        <= '0;
         rptr        <= '0;
         count_q     <= '0;
         wfull_q     <= 1'b0;
         rempty_q    <= 1'b1;
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc) wptr <= wptr + ptr_t'(1);
         if (rd_acc) rptr <= rptr + ptr_t'(1);
         count_q     <= count_next;
         wfull_q     <= (count_next == cnt_t'(DEPTH));
         rempty_q    <= (count_next == '0);
         afull_q     <= (count_next >= cnt_t'(AFULL_TH));
         aempty_q    <= (count_next <= cnt_t'(AEMPTY_TH));
         // A new error event in the same cycle as clr_err keeps the flag set.
         overflow_q  <= (bus.winc && wfull_q)  || (overflow_q  && !bus.clr_err);
         underflow_q <= (bus.rinc && rempty_q) || (underflow_q && !bus.clr_err);
      end
   end

   fifo_mem #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wptr),
      .wdata (bus.wdata),
      .raddr (rptr),
      .rdata (mem_rdata)
   );

   if (RD_MODE == RD_FWFT) begin : g_rd_fwft
      assign bus.rdata = mem_rdata;
   end else begin : g_rd_reg
      logic [DSIZE-1:0] rdata_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)      rdata_q <= '0;
         else if (rd_acc) rdata_q <= mem_rdata;
      end

      assign bus.rdata = rdata_q;
   end

   assign bus.wfull        = wfull_q;
   assign bus.rempty       = rempty_q;
   assign bus.almost_full  = afull_q;
   assign bus.almost_empty = aempty_q;
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench: registered-read and FWFT instances share stimulus and a queue model.
module tb_sync_fifo_flags;
   import fifo_pkg::*;

   localparam int DSIZE     = 8;
   localparam int ASIZE     = 4;
   localparam int DEPTH     = 16;
   localparam int AFULL_TH  = 14;
   localparam int AEMPTY_TH = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sync_fifo_flags_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus0 ();
   sync_fifo_flags_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus1 ();

   sync_fifo_flags #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_TH(AFULL_TH),
                     .AEMPTY_TH(AEMPTY_TH), .FWFT(0)) dut_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   sync_fifo_flags #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_TH(AFULL_TH),
                     .AEMPTY_TH(AEMPTY_TH), .FWFT(1)) dut_fwft (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] model_q[$];
   logic [7:0] exp0[$];
   logic [7:0] exp1[$];
   bit         m_ov = 1'b0;
   bit         m_un = 1'b0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic drive(input bit w, input logic [7:0] d, input bit r, input bit c);
      bus0.winc = w; bus0.wdata = d; bus0.rinc = r; bus0.clr_err = c;
      bus1.winc = w; bus1.wdata = d; bus1.rinc = r; bus1.clr_err = c;
   endtask

   task automatic check_state();
      int n;
      n = model_q.size();
      check("count0",  32'(bus0.count),        32'(n));
      check("wfull0",  32'(bus0.wfull),        32'(n == DEPTH));
      check("rempty0", 32'(bus0.rempty),       32'(n == 0));
      check("afull0",  32'(bus0.almost_full),  32'(n >= AFULL_TH));
      check("aempty0", 32'(bus0.almost_empty), 32'(n <= AEMPTY_TH));
      check("ovf0",    32'(bus0.overflow),     32'(m_ov));
      check("unf0",    32'(bus0.underflow),    32'(m_un));
      check("count1",  32'(bus1.count),        32'(n));
      check("wfull1",  32'(bus1.wfull),        32'(n == DEPTH));
      check("rempty1", 32'(bus1.rempty),       32'(n == 0));
      check("afull1",  32'(bus1.almost_full),  32'(n >= AFULL_TH));
      check("aempty1", 32'(bus1.almost_empty), 32'(n <= AEMPTY_TH));
      check("ovf1",    32'(bus1.overflow),     32'(m_ov));
      check("unf1",    32'(bus1.underflow),    32'(m_un));
      if (n > 0) check("fwft_head", 32'(bus1.rdata), 32'(model_q[0]));
   endtask

   // One clock of stimulus; the model decides acceptance from its own occupancy.
   task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
      bit full, empty;
      logic [7:0] v;
      @(negedge clk);
      drive(w, d, r, c);
      full  = (model_q.size() == DEPTH);
      empty = (model_q.size() == 0);
      m_ov  = (w && full)  || (m_ov && !c);
      m_un  = (r && empty) || (m_un && !c);
      if (r && !empty) begin
         v = model_q.pop_front();
         exp0.push_back(v);
         exp1.push_back(v);
      end
      if (w && !full) model_q.push_back(d);
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic mid_reset();
      @(negedge clk);
      drive(1'b1, 8'h5C, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      model_q.delete();
      exp0.delete();
      exp1.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
      check_state();
      check("rst_rdata0", 32'(bus0.rdata), 32'h0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Registered-read monitor: a handshake seen mid-cycle must deliver its word one cycle later.
   bit         pend0 = 1'b0;
   logic [7:0] last0 = 8'h00;
   always @(negedge clk) begin
      #3;
      if (!rst_n) begin
         pend0 = 1'b0;
         last0 = 8'h00;
      end else begin
         if (pend0) begin
            if (exp0.size() == 0) check("rd0_unexpected", 32'(bus0.rdata), 32'hFFFF_FFFF);
            else begin
               last0 = exp0.pop_front();
               check("rd0_data", 32'(bus0.rdata), 32'(last0));
            end
         end else begin
            check("rd0_hold", 32'(bus0.rdata), 32'(last0));
         end
         pend0 = bus0.rinc && !bus0.rempty;
      end
   end

   // FWFT monitor: the popped word is on rdata during the handshake cycle itself.
   always @(negedge clk) begin
      logic [7:0] e;
      #3;
      if (rst_n && bus1.rinc && !bus1.rempty) begin
         if (exp1.size() == 0) check("rd1_unexpected", 32'(bus1.rdata), 32'hFFFF_FFFF);
         else begin
            e = exp1.pop_front();
            check("rd1_data", 32'(bus1.rdata), 32'(e));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wp, rp;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("init_rdata0", 32'(bus0.rdata), 32'h0);
      rst_n = 1'b1;
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 0, 0);

      for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
      step(1, 8'hEE, 0, 0);
      for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 1);

      for (int i = 0; i < 16; i++) step(1, 8'($urandom), 0, 0);
      step(1, 8'h77, 1, 0);
      step(1, 8'h78, 0, 0);
      step(1, 8'h79, 0, 1);
      step(0, 8'h00, 0, 1);

      while (model_q.size() > 0) step(0, 8'h00, 1, 0);
      step(1, 8'h3C, 1, 0);
      step(0, 8'h00, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 8'($urandom), 0, 0);
      step(1, 8'h44, 1, 0);
      while (model_q.size() > 0) step(0, 8'h00, 1, 0);

      step(1, 8'hA5, 0, 0);
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 0);

      for (int i = 0; i < 40; i++) step(1, 8'($urandom), (i > 0), 0);
      step(0, 8'h00, 1, 0);

      for (int i = 0; i < 400; i++) begin
         case ((i / 50) % 4)
            0: begin wp = 80; rp = 30; end
            1: begin wp = 30; rp = 80; end
            2: begin wp = 95; rp = 90; end
            default: begin wp = 50; rp = 50; end
         endcase
         step(($urandom_range(0, 99) < wp), 8'($urandom), ($urandom_range(0, 99) < rp),
              ($urandom_range(0, 99) < 5));
      end

      for (int i = 0; i < 18; i++) step(1, 8'($urandom), 0, 0);
      mid_reset();
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 1, 0);
      step(1, 8'h96, 0, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 0, 0);

      check("exp0_drained", 32'(exp0.size()), 32'h0);
      check("exp1_drained", 32'(exp1.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO for the FIFO verification environment: it is the single-clock counterpart of the async FIFO DUT. It adds features the async FIFO lacks: an occupancy count, programmable almost-full and almost-empty flags, sticky overflow and underflow error flags with a clear input, and a selectable read mode (registered or first-word-fall-through). It is used as a reference-grade buffer and as a DUT for the flag and error-checking assertions.

Parameters:
DSIZE, 8, data width in bits
ASIZE, 4, address width; DEPTH = 2**ASIZE entries
AFULL_TH, 14, almost_full asserted when count >= AFULL_TH; legal range 1..DEPTH
AEMPTY_TH, 2, almost_empty asserted when count <= AEMPTY_TH; legal range 0..DEPTH-1
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
winc  in  1  write request
wdata  in  DSIZE  write data
rinc  in  1  read request
rdata  out  DSIZE  read data
wfull  out  1  FIFO full
rempty  out  1  FIFO empty
almost_full  out  1  count >= AFULL_TH
almost_empty  out  1  count <= AEMPTY_TH
count  out  ASIZE+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  synchronous clear of overflow and underflow

Behaviour:
- Reset: asynchronous on negedge rst_n. wptr, rptr and count go to 0. rempty=1, wfull=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rdata=0. Memory contents are not reset.
- Accepts: wr_acc = winc && !wfull; rd_acc = rinc && !rempty. Both are evaluated against the registered flags of the current cycle.
- Simultaneous winc and rinc:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: read accepted, write rejected and overflow set; next cycle count = DEPTH-1.
  - Empty: write accepted, read rejected and underflow set; next cycle count = 1.
- Pointers: ASIZE bits wide, increment on accept, wrap DEPTH-1 -> 0 naturally. Write stores wdata at mem[wptr] on the same edge.
- count_next = count + wr_acc - rd_acc, computed at ASIZE+1 bits. It never exceeds DEPTH and never goes below 0.
- All flags are registered and derived from count_next, so they are valid the cycle after the causing edge. No combinational path from inputs to any flag.
  - wfull = (count_next == DEPTH)
  - rempty = (count_next == 0)
  - almost_full = (count_next >= AFULL_TH)
  - almost_empty = (count_next <= AEMPTY_TH)
- Read data, FWFT=0: on rd_acc, rdata <= mem[rptr], visible the cycle after rinc. rdata holds its value otherwise, including while empty.
- Read data, FWFT=1: rdata = mem[rptr] combinationally; the head word is valid whenever rempty=0, and rd_acc pops it. rdata is don't-care while rempty=1.
- Write to an empty FIFO with FWFT=1: the word appears on rdata in the same cycle rempty deasserts (one cycle after the write edge).
- overflow: set on winc && wfull. underflow: set on rinc && rempty. clr_err clears both; if set and clear occur in the same cycle, set wins.
- Illegal parameters (AFULL_TH or AEMPTY_TH out of range) trigger an elaboration-time $error.
- Reset mid-operation: all state returns to reset values immediately. Data written before reset is unreachable afterwards.

Decomposition:
- Package fifo_pkg holds:
  - default DSIZE/ASIZE localparams
  - typedef for the count type (logic [ASIZE:0])
  - typedef for the read mode enum {RD_REG, RD_FWFT}
- One sub-module, fifo_mem: DEPTH x DSIZE dual-port array with synchronous write and asynchronous read, no reset.
- Pointers, count, flags, error logic and read register stay in sync_fifo_flags.

Test Plan:
- Reset then idle -> rempty=1, almost_empty=1, wfull=0, almost_full=0, count=0, overflow=underflow=0, rdata=0.
- Write 16 words 0x00..0x0F (FWFT=0), no reads -> almost_empty drops when count reaches 3, almost_full rises at count=14, wfull=1 at count=16. A 17th winc is rejected, sets overflow=1 and leaves count=16.
- From full, read 16 words -> rdata = 0x00..0x0F in order, each one cycle after its rinc. rempty=1 after the last read. An extra rinc sets underflow=1.
- Simultaneous winc/rinc at count=16 -> count=15, overflow=1. Simultaneous winc/rinc at count=0 -> count=1, underflow=1. At count=5 -> count stays 5.
- FWFT=1: write 0xA5 to an empty FIFO -> next cycle rempty=0 and rdata=0xA5 with no rinc. rinc then gives rempty=1. Write 40 words while draining, to wrap the pointers -> data order preserved.
- Assert clr_err while overflow=1 -> flag cleared next cycle. clr_err together with a new overflow event -> overflow stays 1. rst_n pulled low mid-burst -> all outputs return to reset values asynchronously.
